// File: rtl/ehxplll_divider_model_if.sv
// Phase-control, clock-enable and divided-clock bundle of the EHXPLLL stand-in.
interface ehxplll_divider_model_if;
  logic [1:0] phasesel;
  logic       phasedir;
  logic       phasestep;
  logic       phaseloadreg;
  logic       enclkop;
  logic       enclkos;
  logic       enclkos2;
  logic       enclkos3;
  logic       clkop;
  logic       clkos;
  logic       clkos2;
  logic       clkos3;
  logic       lock;

  modport master (
    output phasesel, phasedir, phasestep, phaseloadreg,
    output enclkop, enclkos, enclkos2, enclkos3,
    input  clkop, clkos, clkos2, clkos3, lock
  );

  modport slave (
    input  phasesel, phasedir, phasestep, phaseloadreg,
    input  enclkop, enclkos, enclkos2, enclkos3,
    output clkop, clkos, clkos2, clkos3, lock
  );
endinterface

// File: rtl/ehxplll_divider_model.sv
// EHXPLLL behavioural stand-in: four phase-steppable integer dividers of clki plus lock; PLL_CLKGATE_EN adds output enables.
// One clki of latency from counter/offset to registered output; no backpressure, stdby freezes counters and silences outputs.
module ehxplll_divider_model #(
  parameter int CLKOP_DIV     = 4,
  parameter int CLKOS_DIV     = 10,
  parameter int CLKOS2_DIV    = 20,
  parameter int CLKOS3_DIV    = 2,
  parameter int CLKOP_CPHASE  = CLKOP_DIV - 1,
  parameter int CLKOS_CPHASE  = CLKOS_DIV - 1,
  parameter int CLKOS2_CPHASE = CLKOS2_DIV - 1,
  parameter int CLKOS3_CPHASE = CLKOS3_DIV - 1,
  parameter int LOCK_CYCLES   = 16
) (
  input logic                      clki,
  input logic                      rst,
  input logic                      stdby,
  ehxplll_divider_model_if.slave   pll
);

  // Channel index follows phasesel encoding: 0=clkos, 1=clkos2, 2=clkos3, 3=clkop.
  function automatic int div_of(input int idx);
    case (idx)
      0:       return CLKOS_DIV;
      1:       return CLKOS2_DIV;
      2:       return CLKOS3_DIV;
      default: return CLKOP_DIV;
    endcase
  endfunction

  function automatic int cphase_of(input int idx);
    case (idx)
      0:       return CLKOS_CPHASE;
      1:       return CLKOS2_CPHASE;
      2:       return CLKOS3_CPHASE;
      default: return CLKOP_CPHASE;
    endcase
  endfunction

  localparam logic [15:0] LOCK_LIMIT = 16'(LOCK_CYCLES);

  logic        step_q;
  logic        load_q;
  logic        step_rise;
  logic        load_rise;
  logic [3:0]  en_q;
  logic [3:0]  clk_vec;
  logic [15:0] lock_cnt;
  logic [15:0] lock_nxt;
  logic        lock_q;

  assign step_rise = pll.phasestep & ~step_q;
  assign load_rise = pll.phaseloadreg & ~load_q;

`ifdef PLL_CLKGATE_EN
  always_ff @(posedge clki) begin
    if (rst) begin
      en_q <= 4'hF;
    end else begin
      en_q <= {pll.enclkop, pll.enclkos3, pll.enclkos2, pll.enclkos};
    end
  end
`else
  assign en_q = 4'hF;
`endif

  for (genvar g = 0; g < 4; g++) begin : g_chan
    localparam int         DIV     = div_of(g);
    localparam logic [7:0] DIV_V   = 8'(DIV);
    localparam logic [7:0] DIV_M1  = 8'(DIV - 1);
    localparam logic [7:0] HALF    = 8'((DIV + 1) / 2);
    // CPHASE of DIV-1 is the zero-offset point.
    localparam logic [7:0] OFF_RST = 8'((cphase_of(g) + 1) % DIV);

    logic [7:0] cnt;
    logic [7:0] off;
    logic [7:0] off_nxt;
    logic [7:0] pos_sum;
    logic [7:0] pos;
    logic       clk_q;

    always_comb begin
      pos_sum = cnt + off;
      pos     = (pos_sum >= DIV_V) ? pos_sum - DIV_V : pos_sum;
      off_nxt = off;
      if (load_rise) begin
        off_nxt = OFF_RST;
      end else if (step_rise && (pll.phasesel == 2'(g))) begin
        if (!pll.phasedir) begin
          off_nxt = (off == DIV_M1) ? 8'd0 : off + 8'd1;
        end else begin
          off_nxt = (off == 8'd0) ? DIV_M1 : off - 8'd1;
        end
      end
    end

    always_ff @(posedge clki) begin
      if (rst) begin
        cnt   <= 8'd0;
        off   <= OFF_RST;
        clk_q <= 1'b0;
      end else if (stdby) begin
        clk_q <= 1'b0;
      end else begin
        cnt   <= (cnt == DIV_M1) ? 8'd0 : cnt + 8'd1;
        off   <= off_nxt;
        clk_q <= (pos < HALF) && en_q[g];
      end
    end

    assign clk_vec[g] = clk_q;
  end

  assign lock_nxt = (lock_cnt == LOCK_LIMIT) ? lock_cnt : lock_cnt + 16'd1;

  // Edge detectors keep sampling in standby so a request held across release is not replayed.
  always_ff @(posedge clki) begin
    if (rst) begin
      step_q   <= 1'b0;
      load_q   <= 1'b0;
      lock_cnt <= 16'd0;
      lock_q   <= 1'b0;
    end else begin
      step_q <= pll.phasestep;
      load_q <= pll.phaseloadreg;
      if (stdby) begin
        lock_cnt <= 16'd0;
        lock_q   <= 1'b0;
      end else begin
        lock_cnt <= lock_nxt;
        lock_q   <= (lock_nxt == LOCK_LIMIT);
      end
    end
  end

  assign pll.clkos  = clk_vec[0];
  assign pll.clkos2 = clk_vec[1];
  assign pll.clkos3 = clk_vec[2];
  assign pll.clkop  = clk_vec[3];
  assign pll.lock   = lock_q;

endmodule

// File: tb/tb_ehxplll_divider_model.sv
// Randomized bench for ehxplll_divider_model against an elapsed-time reference model.
module tb_ehxplll_divider_model;

  logic clki  = 1'b0;
  logic rst   = 1'b1;
  logic stdby = 1'b0;

  always #5 clki = ~clki;

  ehxplll_divider_model_if bus ();
  ehxplll_divider_model_if cph_bus ();

  ehxplll_divider_model u_dut (
    .clki  (clki),
    .rst   (rst),
    .stdby (stdby),
    .pll   (bus)
  );

  ehxplll_divider_model #(.CLKOS_CPHASE(4)) u_cph (
    .clki  (clki),
    .rst   (rst),
    .stdby (stdby),
    .pll   (cph_bus)
  );

  int vec_cnt  = 0;
  int miscmp   = 0;

  // Reference: t counts active cycles since reset; each output is a pure function of t and its offset.
  int  divs [4] = '{10, 20, 2, 4};
  int  off  [4];
  int  t;
  int  act;
  bit  ps_prev;
  bit  pl_prev;
  bit  en_prev [4];
  bit  exp_clk [4];
  bit  exp_lock;
  bit  exp_cph;

  task automatic check(input string tag, input logic got, input logic exp);
    vec_cnt++;
    if (got !== exp) begin
      miscmp++;
      $display("FAIL %s @%0t: got %b expected %b", tag, $time, got, exp);
    end
  endtask

  task automatic model_edge();
    bit rs, rl;
    bit en_now [4];
    en_now = '{bus.enclkos, bus.enclkos2, bus.enclkos3, bus.enclkop};
    if (rst) begin
      t = 0; act = 0; ps_prev = 0; pl_prev = 0;
      for (int i = 0; i < 4; i++) begin
        off[i] = 0; en_prev[i] = 1; exp_clk[i] = 0;
      end
      exp_lock = 0; exp_cph = 0;
    end else begin
      rs = bus.phasestep && !ps_prev;
      rl = bus.phaseloadreg && !pl_prev;
      ps_prev = bus.phasestep;
      pl_prev = bus.phaseloadreg;
      if (stdby) begin
        for (int i = 0; i < 4; i++) exp_clk[i] = 0;
        exp_cph = 0; exp_lock = 0; act = 0;
      end else begin
        for (int i = 0; i < 4; i++)
          exp_clk[i] = (((t + off[i]) % divs[i]) < (divs[i] + 1) / 2) && en_prev[i];
        exp_cph = ((t + 5) % 10) < 5;
        t++; act++;
        exp_lock = (act >= 16);
        if (rl) begin
          for (int i = 0; i < 4; i++) off[i] = 0;
        end else if (rs) begin
          if (!bus.phasedir) off[bus.phasesel] = (off[bus.phasesel] + 1) % divs[bus.phasesel];
          else off[bus.phasesel] = (off[bus.phasesel] + divs[bus.phasesel] - 1) % divs[bus.phasesel];
        end
      end
`ifdef PLL_CLKGATE_EN
      en_prev = en_now;
`endif
    end
  endtask

  task automatic tick();
    @(posedge clki);
    model_edge();
    #1;
    check("clkos",  bus.clkos,  exp_clk[0]);
    check("clkos2", bus.clkos2, exp_clk[1]);
    check("clkos3", bus.clkos3, exp_clk[2]);
    check("clkop",  bus.clkop,  exp_clk[3]);
    check("lock",   bus.lock,   exp_lock);
    check("clkos_cphase4", cph_bus.clkos, exp_cph);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_step(input logic [1:0] sel, input logic dir);
    bus.phasesel = sel; bus.phasedir = dir; bus.phasestep = 1'b1;
    tick();
    bus.phasestep = 1'b0;
    tick();
  endtask

  logic       clkop_hist [8];
  logic       lock_hist  [20];
  logic [7:0] clkop_pat;

  initial begin
    bus.phasesel = 2'd0; bus.phasedir = 1'b0; bus.phasestep = 1'b0; bus.phaseloadreg = 1'b0;
    bus.enclkop = 1'b1; bus.enclkos = 1'b1; bus.enclkos2 = 1'b1; bus.enclkos3 = 1'b1;
    cph_bus.phasesel = 2'd0; cph_bus.phasedir = 1'b0; cph_bus.phasestep = 1'b0;
    cph_bus.phaseloadreg = 1'b0;
    cph_bus.enclkop = 1'b1; cph_bus.enclkos = 1'b1; cph_bus.enclkos2 = 1'b1; cph_bus.enclkos3 = 1'b1;

    // Reset state, then a literal clkop waveform and lock timing independent of the model.
    rst = 1'b1;
    ticks(2);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i < 8) clkop_hist[i] = bus.clkop;
      lock_hist[i] = bus.lock;
    end
    clkop_pat = 8'b00110011;
    for (int i = 0; i < 8; i++) check("clkop_first_edges", clkop_hist[i], clkop_pat[i]);
    check("lock_edge15", lock_hist[14], 1'b0);
    check("lock_edge16", lock_hist[15], 1'b1);

    // Standby pulse then lock reacquire.
    stdby = 1'b1;
    ticks(3);
    stdby = 1'b0;
    ticks(20);

    // clkop advance, held step, retard wrap.
    pulse_step(2'd3, 1'b0);
    ticks(6);
    bus.phasesel = 2'd3; bus.phasedir = 1'b0; bus.phasestep = 1'b1;
    ticks(6);
    bus.phasestep = 1'b0;
    ticks(2);
    bus.phaseloadreg = 1'b1; tick(); bus.phaseloadreg = 1'b0; tick();
    pulse_step(2'd3, 1'b1);
    ticks(8);

    // Two clkos steps, load, then simultaneous step and load.
    pulse_step(2'd0, 1'b0);
    pulse_step(2'd0, 1'b0);
    ticks(10);
    bus.phaseloadreg = 1'b1; tick(); bus.phaseloadreg = 1'b0;
    ticks(12);
    pulse_step(2'd0, 1'b1);
    bus.phasesel = 2'd0; bus.phasedir = 1'b0; bus.phasestep = 1'b1; bus.phaseloadreg = 1'b1;
    tick();
    bus.phasestep = 1'b0; bus.phaseloadreg = 1'b0;
    ticks(12);

    // Phase requests during standby are swallowed.
    stdby = 1'b1;
    tick();
    pulse_step(2'd1, 1'b0);
    stdby = 1'b0;
    ticks(24);

`ifdef PLL_CLKGATE_EN
    bus.enclkos2 = 1'b0;
    ticks(30);
    bus.enclkos2 = 1'b1;
    ticks(45);
`endif

    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom % 600) == 0;
      if (($urandom % 50) == 0) stdby = ~stdby;
      bus.phasestep    = ($urandom % 3) == 0;
      bus.phaseloadreg = ($urandom % 25) == 0;
      bus.phasedir     = 1'($urandom);
      bus.phasesel     = 2'($urandom);
`ifdef PLL_CLKGATE_EN
      bus.enclkop  = ($urandom % 8) != 0;
      bus.enclkos  = ($urandom % 8) != 0;
      bus.enclkos2 = ($urandom % 8) != 0;
      bus.enclkos3 = ($urandom % 8) != 0;
`endif
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end

endmodule
